dmem_access: RTL and testbench
==============================

Name: dmem_access

Overview:
- Data-memory access stage directly downstream of the fixed-mapping address translator.
- Accepts one load/store per transaction with an already-translated physical address.
- Checks alignment, issues a single valid/ready bus request with byte strobes and lane-shifted write data, then waits for the bus response.
- Returns the extended load result, an alignment-error flag or a bus-timeout flag to the pipeline over a valid/ready response channel.

Parameters:
TIMEOUT, 64, cycles waited in WAIT for bus_resp_valid before reporting a bus error (range 1..65535)
CNT_W, 16, width of the timeout counter; must hold TIMEOUT

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  pipeline request present
req_ready  output  1  block can accept a request
req_wr  input  1  1 = store, 0 = load
req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned
req_signed  input  1  sign-extend load result
req_paddr  input  32  physical address from translator
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  pipeline accepts response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_ade  output  1  address-alignment error
resp_berr  output  1  bus timeout error
bus_req_valid  output  1  bus request present
bus_req_ready  input  1  bus accepts request
bus_addr  output  32  req_paddr with bits [1:0] cleared
bus_wr  output  1  write request
bus_wstrb  output  4  byte lane enables; 0 for reads
bus_wdata  output  32  store data replicated/shifted to lanes
bus_resp_valid  input  1  bus response (one cycle)
bus_rdata  input  32  read data, word-aligned

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0, resp_ade=0, resp_berr=0, resp_rdata=0; bus_req_valid=0, bus_wr=0, bus_wstrb=0, bus_addr=0, bus_wdata=0; counter=0.
- Reset mid-transaction abandons it. A bus_resp_valid arriving after reset is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, register wr, size, signed, paddr and wdata.
  - Misaligned request (half with paddr[0]=1, word with paddr[1:0]!=0, or size 3) -> RESP with resp_ade=1. No bus traffic.
  - Aligned request -> REQ.
- REQ:
  - bus_req_valid=1. bus_addr, bus_wr, bus_wstrb and bus_wdata are held stable until bus_req_ready.
  - On handshake -> WAIT; counter cleared.
  - bus_resp_valid is ignored in REQ.
  - No timeout applies in REQ.
- Strobes:
  - byte: 4'b0001 << paddr[1:0]
  - half: 4'b0011 << paddr[1:0]
  - word: 4'b1111
- Write data:
  - byte: wdata[7:0] replicated x4
  - half: wdata[15:0] replicated x2
  - word: wdata unchanged
- WAIT:
  - Counter increments each cycle.
  - bus_resp_valid -> RESP with resp_berr=0.
    - Loads: select byte/half at paddr[1:0] and zero- or sign-extend per req_signed.
    - Stores: resp_rdata=0.
  - Counter reaching TIMEOUT-1 with no response -> RESP with resp_berr=1, resp_rdata=0.
  - bus_resp_valid and timeout in the same cycle: the response wins (berr=0).
- RESP:
  - resp_valid=1; all resp_* outputs held stable until resp_ready.
  - On handshake -> IDLE. resp_valid deasserts the next cycle and req_ready=1 the next cycle; there is no same-cycle turnaround.
  - Late bus_resp_valid after a timeout is discarded.
- Latency: req handshake to resp_valid.
  - Alignment error: 1 cycle.
  - Zero-wait bus (ready at first REQ cycle, response next cycle): 3 cycles.
- Exactly one outstanding transaction; req_ready=0 in REQ, WAIT and RESP.

Test Plan:
- Aligned word load: paddr=0x0000_1004, bus ready immediately, rdata=0xDEADBEEF next cycle -> bus_addr=0x0000_1004, wstrb=0, resp_rdata=0xDEADBEEF, resp_valid 3 cycles after accept.
- Signed byte load: paddr=0x0000_2003, rdata=0x80112233 -> resp_rdata=0xFFFFFF80; repeat with req_signed=0 -> 0x00000080.
- Half store: paddr=0x0000_3002, wdata=0x0000ABCD -> bus_wstrb=4'b1100, bus_wdata=0xABCDABCD, bus_addr=0x0000_3000, resp_rdata=0.
- Misaligned word: paddr=0x0000_4001 -> resp_ade=1 one cycle after accept, bus_req_valid never asserted.
- Backpressure/timeout: bus_req_ready low 5 cycles, then high; bus_resp_valid never arrives with TIMEOUT=8 -> bus fields stable for 5 cycles, resp_berr=1 after 8 WAIT cycles; resp held while resp_ready=0 for 3 cycles.
- Async reset asserted in WAIT -> all outputs 0 and req_ready=1 immediately; following bus_resp_valid produces no resp_valid.

Source files
------------

// File: rtl/dmem_access_if.sv
// Pipeline request/response channel and single-beat data bus for dmem_access.
// The slave modport is the access stage itself; master is its environment.
interface dmem_access_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wr;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_paddr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_ade;
   logic        resp_berr;

   logic        bus_req_valid;
   logic        bus_req_ready;
   logic [31:0] bus_addr;
   logic        bus_wr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic        bus_resp_valid;
   logic [31:0] bus_rdata;

   modport slave (
      input  req_valid, req_wr, req_size, req_signed, req_paddr, req_wdata,
      output req_ready,
      output resp_valid, resp_rdata, resp_ade, resp_berr,
      input  resp_ready,
      output bus_req_valid, bus_addr, bus_wr, bus_wstrb, bus_wdata,
      input  bus_req_ready, bus_resp_valid, bus_rdata
   );

   modport master (
      output req_valid, req_wr, req_size, req_signed, req_paddr, req_wdata,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_ade, resp_berr,
      output resp_ready,
      input  bus_req_valid, bus_addr, bus_wr, bus_wstrb, bus_wdata,
      output bus_req_ready, bus_resp_valid, bus_rdata
   );
endinterface

// File: rtl/dmem_access.sv
// Data-memory access stage: alignment check, one bus transaction per request,
// load extension and bus-timeout reporting over a valid/ready response channel.
module dmem_access #(
   parameter int unsigned TIMEOUT = 32'd64,
   parameter int unsigned CNT_W   = 32'd16
) (
   input  logic         clk,
   input  logic         rst,
   dmem_access_if.slave dm
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 32'd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic              sgn_q, sgn_d;
   logic [1:0]        off_q, off_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       bus_addr_q, bus_addr_d;
   logic              bus_wr_q, bus_wr_d;
   logic [3:0]        bus_wstrb_q, bus_wstrb_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic [31:0]       resp_rdata_q, resp_rdata_d;
   logic              resp_ade_q, resp_ade_d;
   logic              resp_berr_q, resp_berr_d;

   logic              misalign_s;
   logic              cnt_hit_s;
   logic [3:0]        strb_s;
   logic [31:0]       lanes_s;
   logic [31:0]       load_s;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return (off != 2'd0);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'd0:    return 4'b0001 << off;
         2'd1:    return 4'b0011 << off;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'd0:    return {4{wdata[7:0]}};
         2'd1:    return {2{wdata[15:0]}};
         default: return wdata;
      endcase
   endfunction

   // Bus data is word-aligned: shift the addressed lane down before extending.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic sgn);
      logic [31:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         2'd0:    return {{24{sgn & sh[7]}}, sh[7:0]};
         2'd1:    return {{16{sgn & sh[15]}}, sh[15:0]};
         default: return word;
      endcase
   endfunction

   assign misalign_s = is_misaligned(dm.req_size, dm.req_paddr[1:0]);
   assign strb_s     = lane_strobe(dm.req_size, dm.req_paddr[1:0]);
   assign lanes_s    = lane_data(dm.req_size, dm.req_wdata);
   assign load_s     = load_extend(dm.bus_rdata, size_q, off_q, sgn_q);
   assign cnt_hit_s  = (cnt_q == CNT_LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (dm.req_valid) begin
               if (misalign_s) begin
                  state_d = RESP;
               end else begin
                  state_d = REQ;
               end
            end else begin
               state_d = IDLE;
            end
         end
         REQ: begin
            if (dm.bus_req_ready) begin
               state_d = WAIT;
            end else begin
               state_d = REQ;
            end
         end
         WAIT: begin
            if (dm.bus_resp_valid || cnt_hit_s) begin
               state_d = RESP;
            end else begin
               state_d = WAIT;
            end
         end
         RESP: begin
            if (dm.resp_ready) begin
               state_d = IDLE;
            end else begin
               state_d = RESP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; everything not written here holds
   always_comb begin
      wr_d         = wr_q;
      size_d       = size_q;
      sgn_d        = sgn_q;
      off_d        = off_q;
      cnt_d        = cnt_q;
      bus_addr_d   = bus_addr_q;
      bus_wr_d     = bus_wr_q;
      bus_wstrb_d  = bus_wstrb_q;
      bus_wdata_d  = bus_wdata_q;
      resp_rdata_d = resp_rdata_q;
      resp_ade_d   = resp_ade_q;
      resp_berr_d  = resp_berr_q;
      case (state_q)
         IDLE: begin
            if (dm.req_valid) begin
               wr_d         = dm.req_wr;
               size_d       = dm.req_size;
               sgn_d        = dm.req_signed;
               off_d        = dm.req_paddr[1:0];
               resp_rdata_d = 32'h0000_0000;
               resp_ade_d   = misalign_s;
               resp_berr_d  = 1'b0;
               if (misalign_s) begin
                  bus_wr_d = bus_wr_q;
               end else begin
                  bus_addr_d  = {dm.req_paddr[31:2], 2'b00};
                  bus_wr_d    = dm.req_wr;
                  bus_wstrb_d = dm.req_wr ? strb_s : 4'b0000;
                  bus_wdata_d = lanes_s;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         REQ: begin
            if (dm.bus_req_ready) begin
               cnt_d = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q;
            end
         end
         WAIT: begin
            cnt_d = cnt_q + CNT_ONE;
            // A response in the timeout cycle still counts as a good response.
            if (dm.bus_resp_valid) begin
               resp_rdata_d = wr_q ? 32'h0000_0000 : load_s;
               resp_berr_d  = 1'b0;
            end else if (cnt_hit_s) begin
               resp_rdata_d = 32'h0000_0000;
               resp_berr_d  = 1'b1;
            end else begin
               resp_berr_d  = resp_berr_q;
            end
         end
         RESP: begin
            cnt_d = cnt_q;
         end
         default: begin
            cnt_d = {CNT_W{1'b0}};
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q         <= 1'b0;
         size_q       <= 2'd0;
         sgn_q        <= 1'b0;
         off_q        <= 2'd0;
         cnt_q        <= {CNT_W{1'b0}};
         bus_addr_q   <= 32'h0000_0000;
         bus_wr_q     <= 1'b0;
         bus_wstrb_q  <= 4'b0000;
         bus_wdata_q  <= 32'h0000_0000;
         resp_rdata_q <= 32'h0000_0000;
         resp_ade_q   <= 1'b0;
         resp_berr_q  <= 1'b0;
      end else begin
         wr_q         <= wr_d;
         size_q       <= size_d;
         sgn_q        <= sgn_d;
         off_q        <= off_d;
         cnt_q        <= cnt_d;
         bus_addr_q   <= bus_addr_d;
         bus_wr_q     <= bus_wr_d;
         bus_wstrb_q  <= bus_wstrb_d;
         bus_wdata_q  <= bus_wdata_d;
         resp_rdata_q <= resp_rdata_d;
         resp_ade_q   <= resp_ade_d;
         resp_berr_q  <= resp_berr_d;
      end
   end

   assign dm.req_ready     = (state_q == IDLE);
   assign dm.bus_req_valid = (state_q == REQ);
   assign dm.resp_valid    = (state_q == RESP);
   assign dm.bus_addr      = bus_addr_q;
   assign dm.bus_wr        = bus_wr_q;
   assign dm.bus_wstrb     = bus_wstrb_q;
   assign dm.bus_wdata     = bus_wdata_q;
   assign dm.resp_rdata    = resp_rdata_q;
   assign dm.resp_ade      = resp_ade_q;
   assign dm.resp_berr     = resp_berr_q;

endmodule

// File: tb/tb_dmem_access.sv
// Scoreboard bench for dmem_access: directed loads/stores, alignment errors,
// bus backpressure, timeout and asynchronous reset mid-transaction.
module tb_dmem_access;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_access_if dif ();
   dmem_access #(.TIMEOUT(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .dm(dif));

   typedef struct {
      logic [31:0] rdata;
      logic        ade;
      logic        berr;
      int          acc;
      int          lat;
   } resp_t;
   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } breq_t;

   resp_t       resp_q[$];
   breq_t       breq_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          bus_hs_cnt = 0;
   int          cfg_stall = 0;
   int          cfg_delay = 1;
   int          cfg_hold = 0;
   logic [31:0] cfg_rdata = 32'h0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Bus slave model and bus-side monitor
   initial begin : bus_model
      int   stall_left;
      int   countdown;
      logic in_req;
      stall_left = 0; countdown = 0; in_req = 1'b0;
      dif.bus_req_ready = 1'b0; dif.bus_resp_valid = 1'b0; dif.bus_rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (countdown == 1) begin
            dif.bus_resp_valid = 1'b1;
            dif.bus_rdata = cfg_rdata;
         end else begin
            dif.bus_resp_valid = 1'b0;
         end
         if (countdown > 0) countdown--;
         if (dif.bus_req_valid === 1'b1) begin
            if (!in_req) begin
               stall_left = cfg_stall;
               in_req = 1'b1;
            end
            dif.bus_req_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            if (breq_q.size() == 0) begin
               check("bus_unexpected_req", 64'(dif.bus_req_valid), 64'(1'b0));
            end else begin
               check("bus_addr", 64'(dif.bus_addr), 64'(breq_q[0].addr));
               check("bus_wr", 64'(dif.bus_wr), 64'(breq_q[0].wr));
               check("bus_wstrb", 64'(dif.bus_wstrb), 64'(breq_q[0].wstrb));
               if (breq_q[0].wr) check("bus_wdata", 64'(dif.bus_wdata), 64'(breq_q[0].wdata));
               if (dif.bus_req_ready) begin
                  void'(breq_q.pop_front());
                  in_req = 1'b0;
                  countdown = cfg_delay;
                  bus_hs_cnt++;
               end
            end
         end else begin
            dif.bus_req_ready = 1'b0;
            in_req = 1'b0;
         end
      end
   end

   // Response monitor: drives resp_ready backpressure and scores responses
   initial begin : resp_mon
      int   hold_left;
      int   first_cyc;
      logic in_resp;
      hold_left = 0; first_cyc = 0; in_resp = 1'b0;
      dif.resp_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (dif.resp_valid === 1'b1) begin
            if (!in_resp) begin
               in_resp = 1'b1;
               hold_left = cfg_hold;
               first_cyc = cyc;
            end
            dif.resp_ready = (hold_left == 0);
            if (hold_left > 0) hold_left--;
            if (resp_q.size() == 0) begin
               check("resp_unexpected", 64'(dif.resp_valid), 64'(1'b0));
            end else begin
               check("resp_rdata", 64'(dif.resp_rdata), 64'(resp_q[0].rdata));
               check("resp_ade", 64'(dif.resp_ade), 64'(resp_q[0].ade));
               check("resp_berr", 64'(dif.resp_berr), 64'(resp_q[0].berr));
               if (dif.resp_ready) begin
                  check("resp_latency", 64'(first_cyc - resp_q[0].acc), 64'(resp_q[0].lat));
                  void'(resp_q.pop_front());
                  in_resp = 1'b0;
               end
            end
         end else begin
            in_resp = 1'b0;
            dif.resp_ready = 1'b1;
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (dif.req_ready !== 1'b1 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (dif.req_ready !== 1'b1) check("req_ready_timeout", 64'(dif.req_ready), 64'(1'b1));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((resp_q.size() != 0 || breq_q.size() != 0) && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (resp_q.size() != 0 || breq_q.size() != 0) begin
         check("drain_timeout", 64'(resp_q.size() + breq_q.size()), 64'(0));
         resp_q.delete();
         breq_q.delete();
      end
   endtask

   task automatic run(input logic wr, input logic [1:0] size, input logic sgn,
                      input logic [31:0] paddr, input logic [31:0] wdata,
                      input int stall, input int delay, input int hold, input logic [31:0] brdata,
                      input logic [31:0] exp_rdata, input logic exp_ade, input logic exp_berr,
                      input int exp_lat, input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                      input logic [31:0] exp_wdata);
      resp_t r;
      breq_t b;
      cfg_stall = stall; cfg_delay = delay; cfg_hold = hold; cfg_rdata = brdata;
      wait_ready();
      r.rdata = exp_rdata; r.ade = exp_ade; r.berr = exp_berr; r.acc = cyc; r.lat = exp_lat;
      resp_q.push_back(r);
      if (!exp_ade) begin
         b.addr = exp_addr; b.wr = wr; b.wstrb = exp_wstrb; b.wdata = exp_wdata;
         breq_q.push_back(b);
      end
      dif.req_valid = 1'b1; dif.req_wr = wr; dif.req_size = size; dif.req_signed = sgn;
      dif.req_paddr = paddr; dif.req_wdata = wdata;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      drain();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      breq_t b;
      logic  seen;
      rst = 1'b1;
      dif.req_valid = 1'b0; dif.req_wr = 1'b0; dif.req_size = 2'd0; dif.req_signed = 1'b0;
      dif.req_paddr = 32'h0; dif.req_wdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_resp", 64'({dif.resp_valid, dif.resp_ade, dif.resp_berr, dif.resp_rdata}), 64'(0));
      check("reset_bus", 64'({dif.bus_req_valid, dif.bus_wr, dif.bus_wstrb, dif.bus_addr}), 64'(0));
      check("reset_wdata", 64'(dif.bus_wdata), 64'(0));
      check("reset_req_ready", 64'(dif.req_ready), 64'(1'b1));
      rst = 1'b0;
      @(posedge clk); #1;

      //   wr    sz    sg    paddr         wdata         stl dly hld brdata        exp_rdata     ade   berr  lat addr          wstrb    wdata
      run(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0,        0,  1,  0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 3,  32'h0000_1004, 4'b0000, 32'h0);
      run(1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0,        0,  1,  0,  32'h80112233, 32'hFFFFFF80, 1'b0, 1'b0, 3,  32'h0000_2000, 4'b0000, 32'h0);
      run(1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h0,        0,  1,  0,  32'h80112233, 32'h00000080, 1'b0, 1'b0, 3,  32'h0000_2000, 4'b0000, 32'h0);
      run(1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'h0000ABCD, 0,  1,  0,  32'h12345678, 32'h0,        1'b0, 1'b0, 3,  32'h0000_3000, 4'b1100, 32'hABCDABCD);
      run(1'b0, 2'd2, 1'b0, 32'h0000_4001, 32'h0,        0,  1,  0,  32'h0,        32'h0,        1'b1, 1'b0, 1,  32'h0,         4'b0000, 32'h0);
      run(1'b0, 2'd2, 1'b0, 32'h0000_6000, 32'h0,        5,  0,  3,  32'h0,        32'h0,        1'b0, 1'b1, 15, 32'h0000_6000, 4'b0000, 32'h0);
      run(1'b0, 2'd1, 1'b1, 32'h0000_7002, 32'h0,        0,  1,  0,  32'h80011234, 32'hFFFF8001, 1'b0, 1'b0, 3,  32'h0000_7000, 4'b0000, 32'h0);
      run(1'b1, 2'd0, 1'b0, 32'h0000_8001, 32'h1234565A, 0,  2,  0,  32'h0,        32'h0,        1'b0, 1'b0, 4,  32'h0000_8000, 4'b0010, 32'h5A5A5A5A);
      run(1'b0, 2'd3, 1'b0, 32'h0000_9000, 32'h0,        0,  1,  0,  32'h0,        32'h0,        1'b1, 1'b0, 1,  32'h0,         4'b0000, 32'h0);
      run(1'b0, 2'd1, 1'b1, 32'h0000_9001, 32'h0,        0,  1,  0,  32'h0,        32'h0,        1'b1, 1'b0, 1,  32'h0,         4'b0000, 32'h0);
      run(1'b0, 2'd2, 1'b1, 32'h0000_A000, 32'h0,        0,  8,  0,  32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, 10, 32'h0000_A000, 4'b0000, 32'h0);

      // Reset while waiting for the bus; the response arriving afterwards must be ignored.
      cfg_stall = 0; cfg_delay = 4; cfg_hold = 0; cfg_rdata = 32'hFFFF_FFFF;
      wait_ready();
      b.addr = 32'h0000_5000; b.wr = 1'b0; b.wstrb = 4'b0000; b.wdata = 32'h0;
      breq_q.push_back(b);
      dif.req_valid = 1'b1; dif.req_wr = 1'b0; dif.req_size = 2'd2; dif.req_signed = 1'b0;
      dif.req_paddr = 32'h0000_5000; dif.req_wdata = 32'h0;
      @(posedge clk); #1;
      dif.req_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("arst_resp", 64'({dif.resp_valid, dif.resp_ade, dif.resp_berr, dif.resp_rdata}), 64'(0));
      check("arst_bus", 64'({dif.bus_req_valid, dif.bus_wr, dif.bus_wstrb, dif.bus_addr}), 64'(0));
      check("arst_wdata", 64'(dif.bus_wdata), 64'(0));
      check("arst_req_ready", 64'(dif.req_ready), 64'(1'b1));
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (dif.resp_valid === 1'b1) seen = 1'b1;
      end
      check("arst_no_resp", 64'(seen), 64'(1'b0));
      check("arst_req_ready_after", 64'(dif.req_ready), 64'(1'b1));
      check("bus_handshakes", 64'(bus_hs_cnt), 64'(9));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
